// File: rtl/x3_serial_to_bin.sv
// x3_serial_to_bin
//   Serial excess-3 (XS-3) decimal to binary converter. A conversion is
//   DIGITS excess-3 digits long, most significant digit first. Each legal
//   digit folds into the accumulator as acc*10 + digit. An illegal code
//   sets a sticky invalid flag and still counts toward the digit total.
//   The result is held under a valid/ready handshake until it is consumed.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a conversion (looked at only in IDLE)
//   in_valid   in   in_digit is offered for transfer
//   in_digit   in   [3:0] excess-3 digit
//   in_ready   out  digit accepted this cycle (high in ACCUM)
//   out_valid  out  result/invalid are valid (high in DONE)
//   out_ready  in   consumer takes the result
//   result     out  [OUT_W-1:0] binary value, 0 when invalid
//   invalid    out  some digit of this conversion was an illegal code
//   busy       out  high in ACCUM and DONE
module x3_serial_to_bin #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_digit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             invalid,
    output logic             busy
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inv_q, inv_d;

    logic               xfer;
    logic               legal;
    logic [OUT_W-1:0]   digit_val;

    assign xfer      = (state_q == ACCUM) && in_valid;
    assign legal     = (in_digit >= 4'd3) && (in_digit <= 4'd12);
    assign digit_val = OUT_W'(in_digit - 4'd3);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    // Wraps modulo 2^OUT_W if OUT_W is undersized.
                    if (legal) acc_d = acc_q * OUT_W'(10) + digit_val;
                    else       inv_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIGITS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Outputs are qualified by DONE so stale flags never leak into IDLE.
    assign result    = (out_valid && !inv_q) ? acc_q : '0;
    assign invalid   = out_valid && inv_q;

endmodule

// File: tb/tb_x3_serial_to_bin.sv
module tb_x3_serial_to_bin;

    localparam int DIGITS = 4;
    localparam int OUT_W  = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [3:0]       in_digit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;
    logic             invalid;
    logic             busy;

    x3_serial_to_bin #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_digit (in_digit),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .invalid  (invalid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] r;
        logic             inv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: decimal number built from the digit values with plain
    // integer arithmetic; any illegal code forces result 0 and invalid 1.
    function automatic exp_t ref_conv(input logic [3:0] d[DIGITS]);
        exp_t e;
        longint v;
        v     = 0;
        e.inv = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[i] < 3 || d[i] > 12) e.inv = 1'b1;
            else                       v = v * 10 + (d[i] - 3);
        end
        e.r = e.inv ? '0 : OUT_W'(v % (longint'(1) << OUT_W));
        return e;
    endfunction

    // Monitor: every consumed result is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %0d, no result expected", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("invalid", 32'(invalid), 32'(e.inv));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each digit.
    task automatic run_conv(input logic [3:0] d[DIGITS], input int gap, input int bp);
        exp_t e;
        int   g;
        e = ref_conv(d);
        exp_q.push_back(e);
        // in_valid with a junk digit while idle must be ignored
        start    = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            in_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                in_digit = 4'($urandom);
                chk("in_ready_gap", 32'(in_ready), 32'd1);
                tick();
            end
            in_valid = 1'b1;
            in_digit = d[i];
            chk("in_ready_xfer", 32'(in_ready), 32'd1);
            chk("busy_accum", 32'(busy), 32'd1);
            tick();
        end
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            in_valid  = 1'b1;
            in_digit  = 4'($urandom);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'(e.r));
            chk("hold_invalid", 32'(invalid), 32'(e.inv));
            tick();
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("valid_before_take", 32'(out_valid), 32'd1);
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_take", 32'(out_valid), 32'd0);
        chk("busy_after_take", 32'(busy), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_invalid"}, 32'(invalid), 32'd0);
    endtask

    initial begin
        logic [3:0] d[DIGITS];
        rst       = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_digit  = 4'h5;
        out_ready = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        d = '{4'b0100, 4'b0110, 4'b1000, 4'b1100};   // 1359
        run_conv(d, 0, 0);
        d = '{4'b0011, 4'b1101, 4'b0101, 4'b0011};   // illegal digit
        run_conv(d, 0, 0);
        d = '{4'b1100, 4'b1100, 4'b1100, 4'b1100};   // 9999, stalled
        run_conv(d, 3, 0);
        d = '{4'b0101, 4'b0111, 4'b0011, 4'b1001};   // backpressure
        run_conv(d, 0, 5);

        // reset after two digits discards the partial conversion
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_digit = 4'b1000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_idle("midreset");
        d = '{4'b0011, 4'b0011, 4'b0011, 4'b0100};   // 1
        run_conv(d, 0, 0);

        d = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};   // 0
        run_conv(d, 0, 0);
        d = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};   // illegal low edge
        run_conv(d, 0, 0);
        d = '{4'b1111, 4'b0000, 4'b1100, 4'b0011};   // illegal extremes
        run_conv(d, 1, 1);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 99) < 12) d[i] = 4'($urandom);
                else                            d[i] = 4'($urandom_range(3, 12));
            end
            run_conv(d, -1, int'($urandom_range(0, 4)));
        end

        tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x3_serial_to_bin.md
X3_SERIAL_TO_BIN -- requirements
Module: x3_serial_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of excess-3 digits per conversion, range 1..8.
REQ-002 SHALL have parameter OUT_W, default 14: binary result width; must be >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a conversion; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  in_digit holds a digit offered for transfer.
REQ-007 SHALL have port in_digit  input  4  one excess-3 digit, most significant digit first.
REQ-008 SHALL have port in_ready  output  1  block accepts a digit this cycle.
REQ-009 SHALL have port out_valid  output  1  result and invalid are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  OUT_W  binary value of the decimal number.
REQ-012 SHALL have port invalid  output  1  at least one digit in the conversion was not a legal excess-3 code.
REQ-013 SHALL have port busy  output  1  high in ACCUM and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; when start=1, clear the accumulator, digit counter and invalid flag, then go to ACCUM.
REQ-016 ACCUM: in_ready=1; a digit transfers in a cycle where in_valid=1 (in_valid && in_ready).
REQ-017 A legal digit code is 4'b0011..4'b1100 (values 0..9); the decoded value is in_digit-3.
REQ-018 For each legal transfer: acc <= acc*10 + (in_digit-3), truncated modulo 2^OUT_W.
REQ-019 For each illegal transfer (0000-0010 or 1101-1111): set the sticky invalid flag and leave acc unchanged; the digit still counts.
REQ-020 Cycles in ACCUM with in_valid=0 SHALL leave acc, counter and flag unchanged; input gaps of any length are allowed.
REQ-021 On the DIGITS-th transfer SHALL go to DONE; out_valid rises on the next clock edge (latency 1 cycle after the last digit).
REQ-022 DONE: in_ready=0, out_valid=1; result=acc if invalid=0, else result=0.
REQ-023 result and invalid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 SHALL go to IDLE; out_valid is 0 in the following cycle.
REQ-025 start SHALL be ignored in ACCUM and DONE; in IDLE, a start coinciding with the previous handshake's following cycle is accepted normally.
REQ-026 in_digit SHALL be ignored whenever in_ready=0.
REQ-027 DIGITS=1 SHALL degenerate to a single-digit converter with the same handshake.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE from any state, including mid-conversion, and discard partial data.
REQ-029 After reset, the outputs SHALL be in_ready=0, out_valid=0, busy=0, result=0, invalid=0.
REQ-030 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-031 Basic conversion: DIGITS=4, start, then digits 0100, 0110, 1000, 1100 back-to-back -> out_valid 1 cycle after the 4th digit, result=1359 (0x54F), invalid=0.
REQ-032 Illegal digit: digits 0011, 1101, 0101, 0011 -> all four accepted, out_valid=1, invalid=1, result=0.
REQ-033 Stalled input: digits 1100, 1100, 1100, 1100 with 3 idle in_valid=0 cycles between each -> result=9999 (0x270F), in_ready held high throughout ACCUM.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and result stay constant; start pulses are ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-operation: rst after 2 digits, then a new start and digits 0011, 0011, 0011, 0100 -> result=1, invalid=0.
REQ-036 Boundary: digits 0011 x4 -> result=0, invalid=0; in_digit=0010 in the 4th position -> invalid=1.
